// File: rtl/ask_packet_rcv.sv
// ASK packet receiver: preamble phase lock, syncword framing, fixed payload.
// Define ASK_RCV_MAJORITY_EN for majority-vote symbol decisions.
module ask_packet_rcv #(
  parameter int OVERSAMPLE = 4,
  parameter int SAMPLE_POINT = 2,
  parameter int PREAMBLE_WIDTH = 32,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE = 32'hF0F0F0F0,
  parameter int PREAMBLE_BORDER = 31,
  parameter int SYNCWORD_WIDTH = 8,
  parameter logic [SYNCWORD_WIDTH-1:0] SYNCWORD = 8'hE5,
  parameter int SYNCWORD_BORDER = 7,
  parameter int DATA_WIDTH = 8,
  parameter int PAYLOAD_LEN = 4,
  parameter int SYNC_TIMEOUT = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serialin,
  output logic                          locked,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          data_valid,
  output logic [$clog2(PAYLOAD_LEN):0]  word_index,
  output logic                          pkt_done,
  output logic                          sync_timeout
);

  localparam int PCW = $clog2(PREAMBLE_WIDTH) + 1;
  localparam int SCW = $clog2(SYNCWORD_WIDTH) + 1;
  localparam int PHW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam int WCW = $clog2(PAYLOAD_LEN) + 1;
  localparam int TCW = $clog2(SYNC_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_RECV
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sync1, r_sync2, w_smp;
  logic [PREAMBLE_WIDTH-2:0] r_pre;
  logic [PREAMBLE_WIDTH-1:0] w_pre_nxt;
  logic [PCW-1:0] w_pre_cnt;
  logic r_pre_det;
  logic [PHW-1:0] r_phase;
  logic w_strobe, w_bit;
  logic [SYNCWORD_WIDTH-2:0] r_sw;
  logic [SYNCWORD_WIDTH-1:0] w_sw_nxt;
  logic [SCW-1:0] w_sw_cnt;
  logic w_sw_hit;
  logic [TCW-1:0] r_sym_cnt;
  logic [DATA_WIDTH-2:0] r_word;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic [BCW-1:0] r_bit_cnt;
  logic [WCW-1:0] r_word_cnt;
  logic w_timeout, w_word_done, w_pkt_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= serialin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_smp = r_sync2;
  assign w_pre_nxt = {r_pre, w_smp};

  always_comb begin
    w_pre_cnt = '0;
    for (int i = 0; i < PREAMBLE_WIDTH; i++)
      w_pre_cnt = w_pre_cnt + PCW'(w_pre_nxt[i] == PREAMBLE[i]);
  end

  assign w_strobe = (r_phase == PHW'(SAMPLE_POINT));

`ifdef ASK_RCV_MAJORITY_EN
  localparam int OCW = PHW + 1;
  logic [OVERSAMPLE-2:0] r_win;
  logic [OVERSAMPLE-1:0] w_win;
  logic [OCW-1:0] w_ones;

  assign w_win = {r_win, w_smp};

  always_comb begin
    w_ones = '0;
    w_bit = w_smp;
    for (int i = 0; i < OVERSAMPLE; i++)
      w_ones = w_ones + OCW'(w_win[i]);
    if (2 * int'(w_ones) > OVERSAMPLE)
      w_bit = 1'b1;
    else if (2 * int'(w_ones) < OVERSAMPLE)
      w_bit = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_win <= '0;
    else        r_win <= w_win[OVERSAMPLE-2:0];
  end
`else
  assign w_bit = w_smp;
`endif

  assign w_sw_nxt = {r_sw, w_bit};
  assign w_word_nxt = {r_word, w_bit};

  always_comb begin
    w_sw_cnt = '0;
    for (int i = 0; i < SYNCWORD_WIDTH; i++)
      w_sw_cnt = w_sw_cnt + SCW'(w_sw_nxt[i] == SYNCWORD[i]);
  end

  assign w_sw_hit = (w_sw_cnt > SCW'(SYNCWORD_BORDER));

  always_comb begin
    w_state_nxt = r_state;
    w_timeout = 1'b0;
    w_word_done = 1'b0;
    w_pkt_end = 1'b0;
    unique case (r_state)
      S_IDLE: if (r_pre_det) w_state_nxt = S_HUNT;
      S_HUNT: begin
        if (w_strobe) begin
          if (w_sw_hit) begin
            w_state_nxt = S_RECV;
          end else if (r_sym_cnt == TCW'(SYNC_TIMEOUT - 1)) begin
            w_timeout = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RECV: begin
        if (w_strobe && r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
          w_word_done = 1'b1;
          if (r_word_cnt == WCW'(PAYLOAD_LEN - 1)) begin
            w_pkt_end = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_pre_det <= 1'b0;
      r_phase <= '0;
      r_sw <= '0;
      r_sym_cnt <= '0;
      r_word <= '0;
      r_bit_cnt <= '0;
      r_word_cnt <= '0;
      data <= '0;
      word_index <= '0;
      data_valid <= 1'b0;
      pkt_done <= 1'b0;
      sync_timeout <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt[PREAMBLE_WIDTH-2:0];
      r_pre_det <= (w_pre_cnt > PCW'(PREAMBLE_BORDER));
      data_valid <= w_word_done;
      pkt_done <= w_pkt_end;
      sync_timeout <= w_timeout;
      // detects realign phase except while a payload is in flight
      if (r_pre_det && r_state != S_RECV)
        r_phase <= '0;
      else if (r_phase == PHW'(OVERSAMPLE - 1))
        r_phase <= '0;
      else
        r_phase <= r_phase + PHW'(1);
      if (r_state == S_IDLE && r_pre_det) begin
        r_sw <= '0;
        r_sym_cnt <= '0;
      end else if (r_state == S_HUNT && w_strobe) begin
        r_sw <= w_sw_nxt[SYNCWORD_WIDTH-2:0];
        r_sym_cnt <= r_sym_cnt + TCW'(1);
        r_bit_cnt <= '0;
        r_word_cnt <= '0;
      end
      if (r_state == S_RECV && w_strobe) begin
        r_word <= w_word_nxt[DATA_WIDTH-2:0];
        if (w_word_done) begin
          r_bit_cnt <= '0;
          r_word_cnt <= r_word_cnt + WCW'(1);
          data <= w_word_nxt;
          word_index <= r_word_cnt;
        end else begin
          r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
      end
    end
  end

  // stays high through the pkt_done cycle, drops on the next one
  assign locked = (r_state != S_IDLE) || pkt_done;

endmodule
